// File: rtl/grid_scan_ctrl.sv
// grid_scan_ctrl: sweeps a WIDTH x HEIGHT 1-bit grid, counts set cells and records the first one.
// Optional CLEAR_ON_READ_EN: each cell is zeroed in memory at the edge where it is sampled.
module grid_scan_ctrl #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int ADDR_W = 4,
   parameter int ADDR_H = 4,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr_x,
   output logic [ADDR_H-1:0] mem_addr_y,
   output logic              mem_din,
   input  logic              mem_dout,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] first_x,
   output logic [ADDR_H-1:0] first_y,
   output logic [CNT_W-1:0]  ones_count
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_H-1:0] LAST_Y = ADDR_H'(HEIGHT - 1);
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_x, r_fx;
   logic [ADDR_H-1:0] r_y, r_fy;
   logic              r_found;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_last, w_sample;
   assign w_last   = (r_x == LAST_X) && (r_y == LAST_Y);
   // abort wins over sampling, so an aborted cycle neither counts nor clears its cell
   assign w_sample = (r_state == SCAN) && !abort;
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      case (r_state)
         IDLE: w_next = start ? SCAN : IDLE;
         SCAN: begin
            w_next = abort ? IDLE : (w_last ? DONE : SCAN);
            busy   = 1'b1;
            mem_rd = 1'b1;
`ifdef CLEAR_ON_READ_EN
            mem_wr = w_sample;
`endif
         end
         DONE: begin
            w_next = IDLE;
            done   = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_fx    <= '0;
         r_fy    <= '0;
         r_found <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_x     <= '0;
            r_y     <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_found <= 1'b0;
            r_cnt   <= '0;
         end else if (w_sample) begin
            if (mem_dout) begin
               r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
               if (!r_found) begin
                  r_found <= 1'b1;
                  r_fx    <= r_x;
                  r_fy    <= r_y;
               end
            end
            // y is the fast index; the address parks on the last cell once the sweep ends
            if (!w_last) begin
               r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
               r_x <= (r_y == LAST_Y) ? r_x + 1'b1 : r_x;
            end
         end
      end
   end
   assign mem_addr_x = r_x;
   assign mem_addr_y = r_y;
   assign mem_din    = 1'b0;
   assign found      = r_found;
   assign first_x    = r_fx;
   assign first_y    = r_fy;
   assign ones_count = r_cnt;
endmodule
